// File: rtl/ram32x4_pkg.sv
// Shared widths, depth and controller state encoding for the 32x4 RAM arbiter.
package ram32x4_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 32;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/ram32x4_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grants, pointer names the
// requester that wins when both ask.
module rr_arb2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);
  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt0_o = en_i & req0_i & (~req1_i | ~ptr_q);
    gnt1_o = en_i & req1_i & (~req0_i | ptr_q);
    ptr_d  = ptr_q;
    // The requester just served yields priority to the other one.
    if (gnt0_o) begin
      ptr_d = 1'b1;
    end else if (gnt1_o) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: rtl/ram32x4_arbiter.sv
// Two-requester front end for an external 32x4 synchronous-write RAM with an
// optional post-reset fill sweep and registered per-requester read data.
module ram32x4_arbiter
  import ram32x4_pkg::*;
#(
  parameter bit                INIT_CLEAR = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VALUE = 4'h0
) (
  input  logic              WCLK,
  input  logic              CLR_N,
  input  logic              REQ0,
  input  logic              REQ1,
  input  logic              WE0,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] ADR0,
  input  logic [ADDR_W-1:0] ADR1,
  input  logic [DATA_W-1:0] DIN0,
  input  logic [DATA_W-1:0] DIN1,
  output logic              GNT0,
  output logic              GNT1,
  output logic [DATA_W-1:0] DOUT0,
  output logic [DATA_W-1:0] DOUT1,
  output logic              DVAL0,
  output logic              DVAL1,
  output logic [ADDR_W-1:0] RAM_A,
  output logic [DATA_W-1:0] RAM_D,
  output logic              RAM_WE,
  input  logic [DATA_W-1:0] RAM_O,
  output logic              BUSY
);
  state_e            state_q;
  logic              armed_q;
  logic [ADDR_W-1:0] sweep_q;
  logic [ADDR_W-1:0] ram_a_q;
  logic [ADDR_W-1:0] ram_a_d;
  logic [DATA_W-1:0] ram_d_q;
  logic [DATA_W-1:0] ram_d_d;
  logic              ram_we_d;
  logic [DATA_W-1:0] dout0_q;
  logic [DATA_W-1:0] dout1_q;
  logic              dval0_q;
  logic              dval1_q;
  logic              init_wr;
  logic              run_en;
  logic              gnt0;
  logic              gnt1;
  logic              rd0;
  logic              rd1;

  // armed_q keeps the first cycle after reset release free of RAM writes and grants.
  assign init_wr = armed_q && (state_q == ST_INIT);
  assign run_en  = armed_q && (state_q == ST_RUN);

  rr_arb2 u_arb (
    .clk_i  (WCLK),
    .rst_ni (CLR_N),
    .en_i   (run_en),
    .req0_i (REQ0),
    .req1_i (REQ1),
    .gnt0_o (gnt0),
    .gnt1_o (gnt1)
  );

  assign rd0 = gnt0 & ~WE0;
  assign rd1 = gnt1 & ~WE1;

  always_comb begin
    ram_a_d  = ram_a_q;
    ram_d_d  = ram_d_q;
    ram_we_d = 1'b0;
    if (init_wr) begin
      ram_a_d  = sweep_q;
      ram_d_d  = INIT_VALUE;
      ram_we_d = 1'b1;
    end else if (gnt1) begin
      ram_a_d  = ADR1;
      ram_d_d  = DIN1;
      ram_we_d = WE1;
    end else if (gnt0) begin
      ram_a_d  = ADR0;
      ram_d_d  = DIN0;
      ram_we_d = WE0;
    end
  end

  always_ff @(posedge WCLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= INIT_CLEAR ? ST_INIT : ST_RUN;
      armed_q <= 1'b0;
      sweep_q <= '0;
      ram_a_q <= '0;
      ram_d_q <= '0;
    end else begin
      armed_q <= 1'b1;
      ram_a_q <= ram_a_d;
      ram_d_q <= ram_d_d;
      if (init_wr) begin
        sweep_q <= sweep_q + 1'b1;
        if (sweep_q == LAST_ADDR) begin
          state_q <= ST_RUN;
        end
      end
    end
  end

  // RAM_O is combinational from RAM_A, so the grant-cycle value is the read result.
  always_ff @(posedge WCLK or negedge CLR_N) begin
    if (!CLR_N) begin
      dout0_q <= '0;
      dout1_q <= '0;
      dval0_q <= 1'b0;
      dval1_q <= 1'b0;
    end else begin
      dval0_q <= rd0;
      dval1_q <= rd1;
      if (rd0) begin
        dout0_q <= RAM_O;
      end
      if (rd1) begin
        dout1_q <= RAM_O;
      end
    end
  end

  assign GNT0   = gnt0;
  assign GNT1   = gnt1;
  assign DOUT0  = dout0_q;
  assign DOUT1  = dout1_q;
  assign DVAL0  = dval0_q;
  assign DVAL1  = dval1_q;
  assign RAM_A  = ram_a_d;
  assign RAM_D  = ram_d_d;
  assign RAM_WE = ram_we_d;
  assign BUSY   = (state_q == ST_INIT);
endmodule

// File: tb/tb_ram32x4_arbiter.sv
// Randomized and directed bench for ram32x4_arbiter against a transaction-level
// model: a word array for the RAM contents and a "last winner" fairness rule.
module tb_ram32x4_arbiter;
  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [4:0] adr0 = '0, adr1 = '0;
  logic [3:0] din0 = '0, din1 = '0;
  logic       gnt0, gnt1, dval0, dval1, ram_we, busy;
  logic [3:0] dout0, dout1, ram_d, ram_o;
  logic [4:0] ram_a;

  logic       nc_gnt0, nc_gnt1, nc_dval0, nc_dval1, nc_ram_we, nc_busy;
  logic [3:0] nc_dout0, nc_dout1, nc_ram_d;
  logic [4:0] nc_ram_a;

  always #5 clk = ~clk;

  ram32x4_arbiter u_dut (
    .WCLK(clk), .CLR_N(clr_n),
    .REQ0(req0), .REQ1(req1), .WE0(we0), .WE1(we1),
    .ADR0(adr0), .ADR1(adr1), .DIN0(din0), .DIN1(din1),
    .GNT0(gnt0), .GNT1(gnt1), .DOUT0(dout0), .DOUT1(dout1),
    .DVAL0(dval0), .DVAL1(dval1),
    .RAM_A(ram_a), .RAM_D(ram_d), .RAM_WE(ram_we), .RAM_O(ram_o),
    .BUSY(busy)
  );

  ram32x4_arbiter #(.INIT_CLEAR(1'b0)) u_dut_nc (
    .WCLK(clk), .CLR_N(clr_n),
    .REQ0(1'b1), .REQ1(1'b0), .WE0(1'b0), .WE1(1'b0),
    .ADR0(5'd3), .ADR1(5'd0), .DIN0(4'h0), .DIN1(4'h0),
    .GNT0(nc_gnt0), .GNT1(nc_gnt1), .DOUT0(nc_dout0), .DOUT1(nc_dout1),
    .DVAL0(nc_dval0), .DVAL1(nc_dval1),
    .RAM_A(nc_ram_a), .RAM_D(nc_ram_d), .RAM_WE(nc_ram_we), .RAM_O(4'h0),
    .BUSY(nc_busy)
  );

  // The external RAM the DUT drives: synchronous write, asynchronous read.
  logic [3:0] ram_mem [32];
  always @(posedge clk) if (ram_we) ram_mem[ram_a] <= ram_d;
  assign ram_o = ram_mem[ram_a];

  // Reference model state.
  logic [3:0] ref_mem [32];
  logic [3:0] exp_dout [2];
  logic       exp_dval [2];
  int         prefer;
  logic [4:0] exp_last_a;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) ref_mem[i] = 4'h0;
    exp_dout[0] = 4'h0; exp_dout[1] = 4'h0;
    exp_dval[0] = 1'b0; exp_dval[1] = 1'b0;
    prefer = 0;
    exp_last_a = 5'd31;
  endtask

  // Sweep cycles after reset release; REQ1 (read 17) is raised at cycle req1_at.
  task automatic sweep_check(input int ncyc, input int req1_at);
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (k == req1_at) begin
        req1 = 1'b1; we1 = 1'b0; adr1 = 5'd17;
      end
      #1;
      chk("sweep_busy", 32'(busy), 32'd1);
      chk("sweep_we", 32'(ram_we), 32'd1);
      chk("sweep_a", 32'(ram_a), 32'(k));
      chk("sweep_d", 32'(ram_d), 32'h0);
      chk("sweep_gnt1", 32'(gnt1), 32'd0);
      chk("sweep_gnt0", 32'(gnt0), 32'd0);
      if (k == 0) begin
        chk("nc_busy", 32'(nc_busy), 32'd0);
        chk("nc_gnt0_2nd", 32'(nc_gnt0), 32'd1);
      end
    end
  endtask

  // One RUN cycle: check registered outputs from the previous edge, drive the
  // requests, then check grant and RAM port against the model.
  task automatic run_cycle(input logic r0, input logic w0, input logic [4:0] a0, input logic [3:0] d0,
                           input logic r1, input logic w1, input logic [4:0] a1, input logic [3:0] d1,
                           output int win);
    logic       w;
    logic [4:0] a;
    logic [3:0] d;
    @(negedge clk);
    chk("dval0", 32'(dval0), 32'(exp_dval[0]));
    chk("dval1", 32'(dval1), 32'(exp_dval[1]));
    chk("dout0", 32'(dout0), 32'(exp_dout[0]));
    chk("dout1", 32'(dout1), 32'(exp_dout[1]));
    chk("run_busy", 32'(busy), 32'd0);
    req0 = r0; we0 = w0; adr0 = a0; din0 = d0;
    req1 = r1; we1 = w1; adr1 = a1; din1 = d1;
    #1;
    if (r0 && r1) win = prefer;
    else if (r0) win = 0;
    else if (r1) win = 1;
    else win = -1;
    chk("gnt0", 32'(gnt0), 32'(win == 0));
    chk("gnt1", 32'(gnt1), 32'(win == 1));
    exp_dval[0] = 1'b0; exp_dval[1] = 1'b0;
    if (win >= 0) begin
      w = (win == 1) ? w1 : w0;
      a = (win == 1) ? a1 : a0;
      d = (win == 1) ? d1 : d0;
      chk("ram_a", 32'(ram_a), 32'(a));
      chk("ram_we", 32'(ram_we), 32'(w));
      if (w) begin
        chk("ram_d", 32'(ram_d), 32'(d));
        ref_mem[a] = d;
      end else begin
        exp_dout[win] = ref_mem[a];
        exp_dval[win] = 1'b1;
      end
      exp_last_a = a;
      prefer = 1 - win;
      $display("t=%0t req%0d %s adr=%0d din=%0h", $time, win, w ? "WR" : "RD", a, d);
    end else begin
      chk("idle_we", 32'(ram_we), 32'd0);
      chk("idle_a_hold", 32'(ram_a), 32'(exp_last_a));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         win;
    logic       pv [2];
    logic       pw [2];
    logic [4:0] pa [2];
    logic [3:0] pd [2];

    // Reset held with a request pending: nothing may be granted.
    req0 = 1'b1;
    #23;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_dval0", 32'(dval0), 32'd0);
    chk("rst_dout0", 32'(dout0), 32'd0);
    chk("rst_a", 32'(ram_a), 32'd0);
    chk("nc_rst_busy", 32'(nc_busy), 32'd0);
    chk("nc_rst_gnt0", 32'(nc_gnt0), 32'd0);
    req0 = 1'b0;

    // First release: sweep 20 cycles, then abort with a reset pulse.
    @(negedge clk);
    clr_n = 1'b1;
    #1;
    chk("rel_we", 32'(ram_we), 32'd0);
    chk("nc_gnt0_1st", 32'(nc_gnt0), 32'd0);
    sweep_check(20, -1);
    @(negedge clk);
    #1;
    chk("pre_abort_a", 32'(ram_a), 32'd20);
    #1;
    clr_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd1);
    chk("abort_we", 32'(ram_we), 32'd0);
    chk("abort_a", 32'(ram_a), 32'd0);

    // Full sweep with REQ1 raised at cycle 10; it must wait for RUN.
    @(negedge clk);
    clr_n = 1'b1;
    #1;
    chk("rel2_we", 32'(ram_we), 32'd0);
    sweep_check(32, 10);
    model_reset();

    run_cycle(1'b0, 1'b0, 5'd0, 4'h0, 1'b1, 1'b0, 5'd17, 4'h0, win);
    chk("first_run_gnt1", 32'(gnt1), 32'd1);

    // Write then read-back of the same address by the other requester.
    run_cycle(1'b1, 1'b1, 5'd5, 4'hA, 1'b0, 1'b0, 5'd0, 4'h0, win);
    run_cycle(1'b0, 1'b0, 5'd0, 4'h0, 1'b1, 1'b0, 5'd5, 4'h0, win);
    run_cycle(1'b0, 1'b0, 5'd0, 4'h0, 1'b0, 1'b0, 5'd0, 4'h0, win);
    chk("raw_dout1_hold", 32'(dout1), 32'hA);

    // Continuous contention: grants alternate starting with requester 0.
    for (int i = 0; i < 6; i++) begin
      run_cycle(1'b1, 1'b1, 5'(i + 8), 4'(i + 1), 1'b1, 1'b0, 5'(i), 4'h0, win);
      chk("alt_gnt0", 32'(gnt0), 32'(i % 2 == 0));
      chk("alt_gnt1", 32'(gnt1), 32'(i % 2 == 1));
    end

    // Random traffic; an ungranted requester keeps its operands.
    pv[0] = 1'b0; pv[1] = 1'b0;
    pw[0] = 1'b0; pw[1] = 1'b0;
    pa[0] = '0; pa[1] = '0;
    pd[0] = '0; pd[1] = '0;
    for (int c = 0; c < 200; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pv[i] && $urandom_range(0, 3) != 0) begin
          pv[i] = 1'b1;
          pw[i] = 1'($urandom_range(0, 1));
          pa[i] = 5'($urandom_range(0, 7));
          pd[i] = 4'($urandom_range(0, 15));
        end
      end
      run_cycle(pv[0], pw[0], pa[0], pd[0], pv[1], pw[1], pa[1], pd[1], win);
      if (win >= 0) pv[win] = 1'b0;
    end

    // Asynchronous reset while a read result is being presented.
    run_cycle(1'b1, 1'b1, 5'd9, 4'hC, 1'b0, 1'b0, 5'd0, 4'h0, win);
    run_cycle(1'b1, 1'b0, 5'd9, 4'h0, 1'b0, 1'b0, 5'd0, 4'h0, win);
    @(negedge clk);
    #1;
    chk("pre_rst_dval0", 32'(dval0), 32'd1);
    chk("pre_rst_dout0", 32'(dout0), 32'hC);
    #1;
    clr_n = 1'b0;
    #1;
    chk("mid_rst_dval0", 32'(dval0), 32'd0);
    chk("mid_rst_dout0", 32'(dout0), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd1);
    chk("mid_rst_gnt0", 32'(gnt0), 32'd0);
    chk("mid_rst_we", 32'(ram_we), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ram32x4_arbiter.md
RAM32X4_ARBITER -- requirements
Module: ram32x4_arbiter

Interface
REQ-001 SHALL have parameter INIT_CLEAR, default 1, meaning zero-fill all 32 RAM words after reset before serving requests.
REQ-002 SHALL have parameter INIT_VALUE, default 4'h0, meaning the data word written during the init sweep.
REQ-003 WCLK  in  1  single clock; all state updates on rising edge.
REQ-004 CLR_N  in  1  reset, asynchronous, active-low.
REQ-005 REQ0 / REQ1  in  1  requester 0/1 transaction request; held with operands until granted.
REQ-006 WE0 / WE1  in  1  requester 0/1 op select: 1 = write, 0 = read.
REQ-007 ADR0 / ADR1  in  5  requester 0/1 word address.
REQ-008 DIN0 / DIN1  in  4  requester 0/1 write data.
REQ-009 GNT0 / GNT1  out  1  grant; transaction completes in the cycle where REQx and GNTx are both 1.
REQ-010 DOUT0 / DOUT1  out  4  registered read data for requester 0/1.
REQ-011 DVAL0 / DVAL1  out  1  one-cycle pulse: DOUTx valid.
REQ-012 RAM_A  out  5  address to the 32x4 synchronous-write RAM.
REQ-013 RAM_D  out  4  write data to the RAM.
REQ-014 RAM_WE  out  1  write enable to the RAM.
REQ-015 RAM_O  in  4  asynchronous read data from the RAM.
REQ-016 BUSY  out  1  1 while the init sweep runs.

Function
REQ-017 SHALL implement states INIT and RUN; reset enters INIT if INIT_CLEAR=1, else RUN.
REQ-018 In INIT: RAM_A = sweep counter, RAM_D = INIT_VALUE, RAM_WE=1, GNT0=GNT1=0, BUSY=1; counter increments 0..31 once per cycle.
REQ-019 INIT -> RUN on the edge where counter=31 is written; exactly 32 init write cycles; BUSY=0 from the first RUN cycle.
REQ-020 In RUN, at most one grant per cycle; GNTx is combinational from REQ0, REQ1 and the priority pointer.
REQ-021 Single request: granted in the same cycle. Both requesting: the requester named by the pointer wins; the other sees GNT=0 and holds.
REQ-022 Pointer update: after any grant to requester i, pointer = 1-i; no grant leaves pointer unchanged. Neither requester waits more than one cycle under continuous contention.
REQ-023 Granted write: RAM_A=ADRx, RAM_D=DINx, RAM_WE=1 in the grant cycle; data stored at that WCLK edge.
REQ-024 Granted read: RAM_A=ADRx, RAM_WE=0; RAM_O captured into DOUTx at the edge; DVALx=1 for exactly the following cycle. Read latency is 1 cycle.
REQ-025 No grant in RUN: RAM_WE=0; RAM_A, RAM_D hold their last values.
REQ-026 A read granted in the cycle after a write to the same address SHALL return the newly written data.
REQ-027 DOUTx SHALL hold its value between reads; DVALx=0 in cycles with no completed read.
REQ-028 REQx asserted during INIT SHALL be ignored (no grant); it is served in RUN according to REQ-021.

Reset
REQ-029 CLR_N low asynchronously forces: state per REQ-017, sweep counter=0, pointer=0, DOUT0=DOUT1=0, DVAL0=DVAL1=0, BUSY=INIT_CLEAR, GNT0=GNT1=0, RAM_WE=0.
REQ-030 Reset asserted mid-sweep or mid-transaction SHALL abort it; a full sweep restarts after release.
REQ-031 RAM_WE SHALL remain 0 in the first cycle after CLR_N deassertion; the sweep begins in the second cycle.

Structure
REQ-032 Shared package ram32x4_pkg SHALL hold ADDR_W=5, DATA_W=4, DEPTH=32 and the INIT/RUN state encoding.
REQ-033 The 2-way round-robin grant logic and pointer SHALL be a sub-module rr_arb2; the sweep, muxing and read registers stay top-level.

Verification
REQ-034 Reset, INIT_CLEAR=1 -> BUSY=1 for 32 cycles, RAM_A=0..31 with RAM_WE=1 and RAM_D=0, then BUSY=0; a read of address 17 returns 4'h0.
REQ-035 REQ0 write ADR=5 DIN=4'hA, then REQ1 read ADR=5 the next cycle -> DOUT1=4'hA with DVAL1 one cycle after GNT1.
REQ-036 REQ0 and REQ1 both held for 6 cycles -> grants alternate 0,1,0,1,0,1 starting with requester 0.
REQ-037 REQ1 asserted during cycle 10 of the sweep -> GNT1=0 until BUSY=0, then granted in the first RUN cycle.
REQ-038 CLR_N pulsed low at sweep cycle 20 -> outputs return to reset values immediately and the sweep restarts at address 0.
REQ-039 INIT_CLEAR=0 -> BUSY=0 from reset; REQ0 is granted in the second cycle after CLR_N deassertion.
